// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant is held until the owner's last word; a watchdog aborts owners that stall mid-packet.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64,
    localparam int IDW       = $clog2(NUM_REQ),
    localparam int CNTW      = $clog2(TIMEOUT + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [IDW-1:0]                grant_id,
    output logic                          locked,
    output logic                          timeout_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [IDW-1:0]  last_grant, last_grant_nxt;
    logic [CNTW-1:0] idle_cnt, idle_cnt_nxt;
    logic            err_q, err_nxt;
    logic [IDW-1:0]  winner, cand, sel;
    logic [NUM_REQ-1:0] ready;
    logic            xfer;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Lowest rotated offset from rr_ptr wins, so scan offsets from high to low.
    always_comb begin
        winner = rr_ptr;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) winner = cand;
        end
    end

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        idle_cnt_nxt   = idle_cnt;
        err_nxt        = err_q;
        ready          = '0;
        sel            = owner;
        if (!reset) begin
            case (state)
                IDLE: begin
                    sel = winner;
                    if ((|req_valid) && !fifo_full) begin
                        ready[winner]  = 1'b1;
                        last_grant_nxt = winner;
                        if (req_last[winner]) begin
                            rr_ptr_nxt = next_idx(winner);
                        end else begin
                            state_nxt    = LOCKED;
                            owner_nxt    = winner;
                            idle_cnt_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    ready[owner] = !fifo_full;
                    if (req_valid[owner] && !fifo_full) begin
                        idle_cnt_nxt = '0;
                        if (req_last[owner]) begin
                            state_nxt  = IDLE;
                            rr_ptr_nxt = next_idx(owner);
                        end
                    end else if (!req_valid[owner]) begin
                        // Backpressure-only stalls hold the counter; only owner silence counts.
                        if (idle_cnt == CNTW'(TIMEOUT - 1)) begin
                            state_nxt    = IDLE;
                            rr_ptr_nxt   = next_idx(owner);
                            err_nxt      = 1'b1;
                            idle_cnt_nxt = '0;
                        end else begin
                            idle_cnt_nxt = idle_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            last_grant <= '0;
            idle_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            idle_cnt   <= idle_cnt_nxt;
            err_q      <= err_nxt;
        end
    end

    always_comb begin
        xfer        = |(req_valid & ready);
        req_ready   = ready;
        fifo_wr_en  = xfer;
        fifo_data   = xfer ? req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
        locked      = !reset && (state == LOCKED);
        timeout_err = !reset && err_q;
        if (reset)
            grant_id = '0;
        else if (state == LOCKED)
            grant_id = owner;
        else if (xfer)
            grant_id = winner;
        else
            grant_id = last_grant;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, a timeout corner
// sequence, and randomized traffic compared against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            fifo_full, fifo_wr_en;
    logic [DW-1:0]   fifo_data;
    logic [1:0]      grant_id;
    logic            locked, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data(fifo_data), .grant_id(grant_id), .locked(locked),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic [3:0] eReady;
        logic       eWr;
        logic [1:0] eGrant;
        logic       eLocked;
        logic       eErr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a packet is "open" for one requester, priority pointer rotates past
    // whoever finished; silence counter tracks consecutive owner-invalid cycles.
    bit  mOpen, mErr;
    int  mPtr, mOwner, mSilent, mLast;
    logic [3:0]  eReady;
    logic        eWr, eLocked, eErr;
    logic [31:0] eData;
    logic [1:0]  eGrant;

    function automatic logic [31:0] wordOf(input logic [N*DW-1:0] d, input int i);
        return d[i*DW +: DW];
    endfunction

    task automatic modelStep();
        int w;
        eReady  = '0;
        eWr     = 1'b0;
        eData   = '0;
        eGrant  = 2'(mLast);
        eLocked = mOpen;
        eErr    = mErr;
        w = -1;
        if (reset) begin
            eGrant = '0; eLocked = 1'b0; eErr = 1'b0;
            mOpen = 0; mErr = 0; mPtr = 0; mOwner = 0; mSilent = 0; mLast = 0;
        end else if (!mOpen) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(mPtr + k) % N]) w = (mPtr + k) % N;
            if (w >= 0 && !fifo_full) begin
                eReady[w] = 1'b1;
                eWr       = 1'b1;
                eData     = wordOf(req_data, w);
                eGrant    = 2'(w);
                mLast     = w;
                if (req_last[w]) mPtr = (w + 1) % N;
                else begin mOpen = 1; mOwner = w; mSilent = 0; end
            end
        end else begin
            eGrant = 2'(mOwner);
            if (!fifo_full) eReady[mOwner] = 1'b1;
            if (req_valid[mOwner] && !fifo_full) begin
                eWr     = 1'b1;
                eData   = wordOf(req_data, mOwner);
                mSilent = 0;
                if (req_last[mOwner]) begin mOpen = 0; mPtr = (mOwner + 1) % N; end
            end else if (!req_valid[mOwner]) begin
                if (mSilent == TO - 1) begin
                    mOpen = 0; mPtr = (mOwner + 1) % N; mErr = 1; mSilent = 0;
                end else mSilent++;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] v, input logic [3:0] l,
                                 input logic f, input logic [N*DW-1:0] d);
        @(negedge clk);
        reset     = rst;
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        req_data  = d;
        #1;
        modelStep();
    endtask

    task automatic compareModel(input string tag);
        checkOutput({tag, ".ready"},  32'(req_ready),   32'(eReady));
        checkOutput({tag, ".wr_en"},  32'(fifo_wr_en),  32'(eWr));
        checkOutput({tag, ".data"},   fifo_data,        eData);
        checkOutput({tag, ".grant"},  32'(grant_id),    32'(eGrant));
        checkOutput({tag, ".locked"}, 32'(locked),      32'(eLocked));
        checkOutput({tag, ".err"},    32'(timeout_err), 32'(eErr));
    endtask

    task automatic addVec(input logic rst, input logic [3:0] v, input logic [3:0] l, input logic f,
                          input logic [3:0] er, input logic ew, input logic [1:0] eg,
                          input logic el, input logic ee);
        vec_t x;
        x.rst = rst; x.valid = v; x.last = l; x.full = f;
        x.eReady = er; x.eWr = ew; x.eGrant = eg; x.eLocked = el; x.eErr = ee;
        vecs.push_back(x);
    endtask

    initial begin
        logic [N*DW-1:0] d;
        logic [3:0]      lastBits;
        logic [31:0]     expData;
        string           tag;

        reset = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;

        // reset, then single-word round robin
        addVec(1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);
        addVec(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 2, 0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 3, 0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 0, 0);
        addVec(1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);
        addVec(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        // packet lock on req0 with req1 waiting, five backpressure cycles mid-packet
        addVec(0, 4'b0011, 4'b0010, 0, 4'b0001, 1, 0, 0, 0);
        addVec(0, 4'b0011, 4'b0010, 0, 4'b0001, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            addVec(0, 4'b0011, 4'b0010, 1, 4'b0000, 0, 0, 1, 0);
        addVec(0, 4'b0011, 4'b0011, 0, 4'b0001, 1, 0, 1, 0);
        addVec(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 0, 0);
        // timeout on req2, then req3 granted
        addVec(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 0, 0);
        for (int i = 0; i < 4; i++)
            addVec(0, 4'b1000, 4'b1000, 0, 4'b0100, 0, 2, 1, 0);
        addVec(0, 4'b1000, 4'b1000, 0, 4'b1000, 1, 3, 0, 1);
        // wrap: pointer at 3, only req1 valid, pointer then at 2
        addVec(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 2, 0, 1);
        addVec(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 0, 1);
        addVec(0, 4'b1110, 4'b1110, 0, 4'b0100, 1, 2, 0, 1);
        addVec(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2, 0, 1);
        // reset mid-packet
        addVec(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 0, 1);
        addVec(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 1, 1);
        addVec(1, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        addVec(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 0, 0);

        for (int v = 0; v < vecs.size(); v++) begin
            for (int i = 0; i < N; i++)
                d[i*DW +: DW] = 32'hA000_0000 | (32'(i) << 8) | 32'(v);
            applyStimulus(vecs[v].rst, vecs[v].valid, vecs[v].last, vecs[v].full, d);
            expData = vecs[v].eWr ? wordOf(d, int'(vecs[v].eGrant)) : 32'h0;
            tag = $sformatf("vec%0d", v);
            checkOutput({tag, ".ready"},  32'(req_ready),   32'(vecs[v].eReady));
            checkOutput({tag, ".wr_en"},  32'(fifo_wr_en),  32'(vecs[v].eWr));
            checkOutput({tag, ".data"},   fifo_data,        expData);
            checkOutput({tag, ".grant"},  32'(grant_id),    32'(vecs[v].eGrant));
            checkOutput({tag, ".locked"}, 32'(locked),      32'(vecs[v].eLocked));
            checkOutput({tag, ".err"},    32'(timeout_err), 32'(vecs[v].eErr));
        end

        // Silence counter must hold, not clear, across full-only stalls.
        d = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        applyStimulus(1, 4'b0000, 4'b0000, 0, d); compareModel("hs_rst");
        applyStimulus(0, 4'b0001, 4'b0000, 0, d); compareModel("hs_lock");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 4'b0000, 4'b0000, 0, d); compareModel($sformatf("hs_quiet%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'b0001, 4'b0000, 1, d); compareModel($sformatf("hs_full%0d", i));
        end
        applyStimulus(0, 4'b0000, 4'b0000, 0, d); compareModel("hs_quiet2");
        checkOutput("hs_still_locked", 32'(locked), 32'd1);
        applyStimulus(0, 4'b0000, 4'b0000, 0, d); compareModel("hs_abort");
        applyStimulus(0, 4'b0000, 4'b0000, 0, d); compareModel("hs_after");
        checkOutput("hs_unlocked", 32'(locked), 32'd0);
        checkOutput("hs_err_set", 32'(timeout_err), 32'd1);

        // randomized traffic against the model
        applyStimulus(1, 4'b0000, 4'b0000, 0, d); compareModel("rnd_rst");
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                d[i*DW +: DW] = $urandom;
                lastBits[i]   = ($urandom_range(2) == 0);
            end
            applyStimulus($urandom_range(149) == 0, 4'($urandom_range(15)), lastBits,
                          $urandom_range(4) == 0, d);
            compareModel($sformatf("rnd%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
